// File: rtl/uart_frame_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared types and constants for the UART transmit-side frame scheduler.
//   frame_state_t     : scheduler FSM states
//   FRAME_SYNC0/1     : default sync bytes that open every frame
//   FRAME_HDR_BYTES   : sync0 + sync1 + length
//   frame_state_is_tx : 1 for states that offer a byte to the transmitter
// -----------------------------------------------------------------------------
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC0 = 3'd1,
        S_SYNC1 = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6
    } frame_state_t;

    localparam logic [7:0] FRAME_SYNC0     = 8'h55;
    localparam logic [7:0] FRAME_SYNC1     = 8'hAA;
    localparam int         FRAME_HDR_BYTES = 3;

    function automatic logic frame_state_is_tx(input frame_state_t s);
        case (s)
            S_SYNC0, S_SYNC1, S_LEN, S_DATA, S_CSUM: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_frame_scheduler_if
// Bundles the requester-side and transmitter-side signals of the scheduler.
//   req/req_len/req_data : requester requests, lengths and current bytes
//   grant/data_pop       : per-requester grant and byte-consumed pulse
//   frame_done/busy      : frame status
//   tx_data/tx_valid/tx_ready : byte handshake to the TX serializer
// Modports: master = scheduler, slave = requesters + transmitter.
// -----------------------------------------------------------------------------
interface uart_frame_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_len;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   data_pop;
    logic                 frame_done;
    logic                 busy;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        input  req, req_len, req_data, tx_ready,
        output grant, data_pop, frame_done, busy, tx_data, tx_valid
    );

    modport slave (
        output req, req_len, req_data, tx_ready,
        input  grant, data_pop, frame_done, busy, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_frame_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request found when
// searching upward (with wrap) from i_rr_ptr wins.
//   i_req    : request vector
//   i_rr_ptr : index where the search starts
//   o_grant  : one-hot winner (all zero if no request)
//   o_idx    : winner index (0 if no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx
);

    // Rotating priority search; each position is visited exactly once.
    always_comb begin
        logic found;
        logic take;
        int   pos;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        take    = 1'b0;
        pos     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos          = (int'(i_rr_ptr) + k) % NUM_REQ;
            take         = ~found & i_req[pos];
            o_grant[pos] = take;
            o_idx        = take ? IW'(pos) : o_idx;
            found        = found | take;
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// -----------------------------------------------------------------------------
// uart_frame_scheduler
// Shares one byte-wide UART transmitter between NUM_REQ requesters. Picks a
// winner round-robin and sends one frame: SYNC0, SYNC1, length, payload and,
// when FRAME_CHECKSUM_EN is defined, an XOR checksum of length + payload.
//   clock : single clock, posedge
//   reset : asynchronous, active-high
//   bus   : uart_frame_scheduler_if.master (requester + transmitter signals)
// Build option: `define FRAME_CHECKSUM_EN to append the checksum byte.
// -----------------------------------------------------------------------------
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int         NUM_REQ = 4,
    parameter logic [7:0] SYNC0   = FRAME_SYNC0,
    parameter logic [7:0] SYNC1   = FRAME_SYNC1
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_frame_scheduler_if.master bus
);

    localparam int IW = $clog2(NUM_REQ);

`ifdef FRAME_CHECKSUM_EN
    localparam frame_state_t TAIL_STATE = S_CSUM;
`else
    localparam frame_state_t TAIL_STATE = S_DONE;
`endif

    frame_state_t         r_state;
    frame_state_t         w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_win_grant;
    logic [IW-1:0]        r_gidx;
    logic [IW-1:0]        w_win_idx;
    logic [IW-1:0]        r_rr_ptr;
    logic [IW-1:0]        w_rr_nxt;
    logic [7:0]           r_len_q;
    logic [7:0]           r_cnt;
    logic [7:0]           w_win_len;
    logic [7:0]           w_cur_data;
    logic [7:0]           w_tx_data;
    logic                 r_tx_valid;
    logic                 r_frame_done;
    logic                 r_busy;
    logic                 w_fire;
    logic                 w_any_req;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]           r_csum_q;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_win_grant),
        .o_idx    (w_win_idx)
    );

    assign w_any_req  = |bus.req;
    assign w_fire     = r_tx_valid & bus.tx_ready;
    assign w_win_len  = bus.req_len[{w_win_idx, 3'b000} +: 8];
    assign w_cur_data = bus.req_data[{r_gidx, 3'b000} +: 8];
    assign w_rr_nxt   = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + IW'(1);

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: header/payload states advance only on a transfer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_SYNC0; else w_state_nxt = S_IDLE;
            S_SYNC0: if (w_fire)    w_state_nxt = S_SYNC1; else w_state_nxt = S_SYNC0;
            S_SYNC1: if (w_fire)    w_state_nxt = S_LEN;   else w_state_nxt = S_SYNC1;
            S_LEN: begin
                // zero-length frames skip DATA so cnt never wraps
                if (w_fire) begin
                    if (r_len_q == 8'd0) w_state_nxt = TAIL_STATE;
                    else                 w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_LEN;
                end
            end
            S_DATA:  if (w_fire && (r_cnt == 8'd1)) w_state_nxt = TAIL_STATE; else w_state_nxt = S_DATA;
            S_CSUM:  if (w_fire) w_state_nxt = S_DONE; else w_state_nxt = S_CSUM;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte mux toward the transmitter; payload passes straight through the grant mux
    always_comb begin
        w_tx_data = 8'h00;
        case (r_state)
            S_SYNC0: w_tx_data = SYNC0;
            S_SYNC1: w_tx_data = SYNC1;
            S_LEN:   w_tx_data = r_len_q;
            S_DATA:  w_tx_data = w_cur_data;
`ifdef FRAME_CHECKSUM_EN
            S_CSUM:  w_tx_data = r_csum_q;
`endif
            default: w_tx_data = 8'h00;
        endcase
    end

    // Grant, length/count latching, checksum accumulation and rr pointer update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_len_q  <= 8'd0;
            r_cnt    <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
            r_csum_q <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_win_grant;
                        r_gidx  <= w_win_idx;
                        r_len_q <= w_win_len;
                        r_cnt   <= w_win_len;
                    end
`ifdef FRAME_CHECKSUM_EN
                    r_csum_q <= 8'd0;
`endif
                end
`ifdef FRAME_CHECKSUM_EN
                S_LEN: begin
                    if (w_fire) r_csum_q <= r_csum_q ^ r_len_q;
                end
`endif
                S_DATA: begin
                    if (w_fire) begin
                        r_cnt <= r_cnt - 8'd1;
`ifdef FRAME_CHECKSUM_EN
                        r_csum_q <= r_csum_q ^ w_cur_data;
`endif
                    end
                end
                S_DONE: begin
                    r_grant  <= '0;
                    r_rr_ptr <= w_rr_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status outputs, derived from the state being entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_tx_valid   <= frame_state_is_tx(w_state_nxt);
            r_frame_done <= (w_state_nxt == S_DONE);
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.grant      = r_grant;
    assign bus.data_pop   = ((r_state == S_DATA) && w_fire) ? r_grant : '0;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;
    assign bus.tx_data    = w_tx_data;
    assign bus.tx_valid   = r_tx_valid;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_scheduler
// Scoreboard bench: the stimulus process queues the expected byte stream of
// every frame it requests; a negedge monitor pops and compares on each
// transfer and checks data_pop / frame_done alongside.
// -----------------------------------------------------------------------------
module tb_uart_frame_scheduler;
    import uart_frame_pkg::*;

    localparam int NR = 4;

    typedef struct {
        logic [7:0] data;
        int         g;
        bit         pay;
        bit         first;
        bit         last;
        int         flen;
    } exp_t;

    logic clock;
    logic reset;
    uart_frame_scheduler_if #(.NUM_REQ(NR)) bus ();

    uart_frame_scheduler #(.NUM_REQ(NR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         checks    = 0;
    int         failures  = 0;
    int         done_cnt  = 0;
    int         cyc       = 0;
    int         last_cyc  = -10;
    int         last_flen = 0;
    int         xfer_cnt  = 0;
    bit         seen_idle = 1'b1;
    exp_t       sbq[$];
    logic [7:0] pay [NR][8];
    int         pidx [NR];
    logic [NR-1:0] pend;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input int g, input int len);
        exp_t       e;
        logic [7:0] cs;
        int         flen;
        flen = FRAME_HDR_BYTES + len;
`ifdef FRAME_CHECKSUM_EN
        flen = flen + 1;
`endif
        e.g = g; e.pay = 1'b0; e.last = 1'b0; e.flen = flen;
        e.first = 1'b1; e.data = FRAME_SYNC0; sbq.push_back(e);
        e.first = 1'b0; e.data = FRAME_SYNC1; sbq.push_back(e);
        e.data = 8'(len); sbq.push_back(e);
        cs = 8'(len);
        e.pay = 1'b1;
        for (int i = 0; i < len; i++) begin
            e.data = pay[g][i];
            cs = cs ^ pay[g][i];
            sbq.push_back(e);
        end
`ifdef FRAME_CHECKSUM_EN
        e.pay = 1'b0; e.data = cs; sbq.push_back(e);
`endif
        sbq[sbq.size()-1].last = 1'b1;
    endfunction

    // Requester model: present pay[i][pidx[i]], advance after each consumed byte
    always_comb begin
        for (int i = 0; i < NR; i++) bus.req_data[8*i +: 8] = pay[i][pidx[i]];
    end

    initial begin
        pend = '0;
        for (int i = 0; i < NR; i++) pidx[i] = 0;
        forever begin
            @(negedge clock);
            pend = bus.data_pop;
            @(posedge clock);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (pend[i]) pidx[i] = pidx[i] + 1;
                if (!bus.grant[i]) pidx[i] = 0;
            end
        end
    end

    // Monitor: compare every transfer against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                if (!bus.busy) seen_idle = 1'b1;
                if (bus.tx_valid && bus.tx_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = sbq.pop_front();
                        chk("tx_data", {24'd0, bus.tx_data}, {24'd0, e.data});
                        chk("grant", 32'(bus.grant), 32'd1 << e.g);
                        chk("data_pop", 32'(bus.data_pop), e.pay ? (32'd1 << e.g) : 32'd0);
                        if (e.first) begin
                            chk("idle_gap", {31'd0, seen_idle}, 32'd1);
                            seen_idle = 1'b0;
                            xfer_cnt  = 0;
                        end
                        xfer_cnt++;
                        if (e.last) begin
                            last_cyc  = cyc;
                            last_flen = e.flen;
                        end
                    end
                end else if (bus.tx_valid) begin
                    chk("stall_no_pop", 32'(bus.data_pop), 32'd0);
                end
                if (bus.frame_done) begin
                    chk("done_after_last", cyc, last_cyc + 1);
                    chk("frame_len", xfer_cnt, last_flen);
                    done_cnt++;
                end
            end
        end
    end

    task automatic wait_done(input int n);
        for (int k = 0; k < 400 && done_cnt < n; k++) @(negedge clock);
        chk("frame_done_count", done_cnt, n);
    endtask

    task automatic wait_grant(input int g);
        for (int k = 0; k < 200 && !bus.grant[g]; k++) @(negedge clock);
        chk("grant_wait", {31'd0, bus.grant[g]}, 32'd1);
    endtask

    task automatic wait_pop(input int g);
        for (int k = 0; k < 200 && !bus.data_pop[g]; k++) @(negedge clock);
        chk("pop_wait", {31'd0, bus.data_pop[g]}, 32'd1);
    endtask

    // Raise req[g] from IDLE and check the one-cycle grant latency
    task automatic raise(input int g);
        @(posedge clock); #1;
        bus.req[g] = 1'b1;
        @(negedge clock);
        chk("grant_before_latency", 32'(bus.grant), 32'd0);
        @(negedge clock);
        chk("grant_latency", 32'(bus.grant), 32'd1 << g);
        chk("sync0_valid", {31'd0, bus.tx_valid}, 32'd1);
        chk("sync0_data", {24'd0, bus.tx_data}, 32'h55);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_data_pop"}, 32'(bus.data_pop), 32'd0);
        chk({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_tx_valid"}, {31'd0, bus.tx_valid}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired done=%0d required=9", done_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 8; j++) pay[i][j] = 8'h00;
        bus.req      = '0;
        bus.req_len  = '0;
        bus.tx_ready = 1'b1;
        reset        = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Round robin: req0 and req2 held together -> 0, 2, 0, 2
        pay[0][0] = 8'hA0;                     bus.req_len[7:0]   = 8'd1;
        pay[2][0] = 8'hB0; pay[2][1] = 8'hB1;  bus.req_len[23:16] = 8'd2;
        push_frame(0, 1); push_frame(2, 2); push_frame(0, 1); push_frame(2, 2);
        @(posedge clock); #1 bus.req = 4'b0101;
        wait_done(3);
        wait_grant(2);
        @(posedge clock); #1 bus.req = 4'b0000;
        wait_done(4);

        // Single frame on req1: 55 AA 02 11 22 (31)
        pay[1][0] = 8'h11; pay[1][1] = 8'h22; bus.req_len[15:8] = 8'd2;
        push_frame(1, 2);
        raise(1);
        @(posedge clock); #1 bus.req = 4'b0000;
        wait_done(5);

        // Zero length on req3: 55 AA 00 (00), no data_pop
        bus.req_len[31:24] = 8'd0;
        push_frame(3, 0);
        raise(3);
        @(posedge clock); #1 bus.req = 4'b0000;
        wait_done(6);

        // Backpressure for 5 cycles in DATA on req2
        pay[2][0] = 8'hC0; pay[2][1] = 8'hC1; pay[2][2] = 8'hC2; pay[2][3] = 8'hC3;
        bus.req_len[23:16] = 8'd4;
        push_frame(2, 4);
        raise(2);
        @(posedge clock); #1 bus.req = 4'b0000;
        wait_pop(2);
        @(posedge clock); #1 bus.tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_tx_data", {24'd0, bus.tx_data}, 32'hC1);
            chk("bp_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
            chk("bp_grant", 32'(bus.grant), 32'd4);
        end
        @(posedge clock); #1 bus.tx_ready = 1'b1;
        wait_done(7);

        // req1 drops its request after SYNC1; the frame still completes
        pay[1][0] = 8'hD0; pay[1][1] = 8'hD1; pay[1][2] = 8'hD2; bus.req_len[15:8] = 8'd3;
        push_frame(1, 3);
        raise(1);
        for (int k = 0; k < 50 && !(bus.tx_valid && bus.tx_ready && bus.tx_data == 8'hAA); k++)
            @(negedge clock);
        chk("sync1_seen", {24'd0, bus.tx_data}, 32'hAA);
        @(posedge clock); #1 bus.req = 4'b0000;
        wait_done(8);

        // Reset in the middle of DATA, then restart with rr_ptr back at 0
        pay[0][0] = 8'hE0; pay[0][1] = 8'hE1; pay[0][2] = 8'hE2; pay[0][3] = 8'hE3; pay[0][4] = 8'hE4;
        bus.req_len[7:0] = 8'd5;
        push_frame(0, 5);
        raise(0);
        @(posedge clock); #1 bus.req = 4'b0000;
        wait_pop(0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        sbq.delete();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        chk("no_done_on_abort", done_cnt, 8);
        pay[1][0] = 8'hF0; bus.req_len[15:8] = 8'd1;
        push_frame(1, 1);
        @(posedge clock); #1 bus.req = 4'b1010;
        @(negedge clock);
        chk("post_reset_idle", 32'(bus.grant), 32'd0);
        @(negedge clock);
        chk("post_reset_rr_ptr", 32'(bus.grant), 32'd2);
        @(posedge clock); #1 bus.req = 4'b0000;
        wait_done(9);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Transmit-side frame controller that shares a single byte-wide UART transmitter between `NUM_REQ` requesters. It arbitrates round-robin, then sequences one complete frame for the winner: sync byte 0x55, sync byte 0xAA, length byte, payload bytes, and an optional checksum. This is the same frame format the receive path parses. It sits between the client blocks and the TX serializer.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `SYNC0`, default 8'h55: first sync byte.
- `SYNC1`, default 8'hAA: second sync byte.
- `clock`  in  1: single clock; all logic on posedge.
- `reset`  in  1: asynchronous, active-high. Clears all state immediately.
- `req`  in  NUM_REQ: requester i holds `req[i]` high while it wants to send a frame.
- `req_len`  in  8*NUM_REQ: payload length of requester i in bits [8i+7:8i]. Range 0..255.
- `req_data`  in  8*NUM_REQ: current payload byte of requester i. Must be valid while `grant[i]` is high.
- `grant`  out  NUM_REQ: one-hot, held for the whole frame.
- `data_pop`  out  NUM_REQ: 1-cycle pulse when requester i's current byte is consumed. The requester presents its next byte on the following cycle.
- `frame_done`  out  1: 1-cycle pulse after the last byte of a frame is accepted.
- `busy`  out  1: high in every state except IDLE.
- `tx_data`  out  8: byte to the transmitter.
- `tx_valid`  out  1: byte offer to the transmitter.
- `tx_ready`  in  1: transmitter can accept a byte. A byte transfers on a cycle where `tx_valid` and `tx_ready` are both high.

## Operation
- States: IDLE, SYNC0, SYNC1, LEN, DATA, CSUM, DONE.
- IDLE:
  - If any `req` is high, select a winner round-robin, starting the search at `rr_ptr`.
  - Register the winner's `grant`, latch its `req_len` into `len_q` and `cnt`, and go to SYNC0.
- SYNC0, SYNC1, LEN:
  - Drive `tx_data` = SYNC0, SYNC1, `len_q` respectively, with `tx_valid` = 1.
  - Advance only on a transfer.
- LEN exit on transfer: if `len_q` == 0, go to CSUM (or DONE when the checksum is compiled out); otherwise go to DATA.
- DATA:
  - `tx_data` = granted requester's `req_data`, passed combinationally through the grant mux. `tx_valid` = 1.
  - On each transfer: pulse `data_pop[g]` in the same cycle and decrement `cnt`.
  - When `cnt` is 1 at the transfer, go to CSUM or DONE.
- CSUM: `tx_data` = `csum_q`, `tx_valid` = 1. Go to DONE on transfer.
- DONE (1 cycle):
  - `tx_valid` = 0 and `frame_done` = 1.
  - Clear `grant`, set `rr_ptr` = (g+1) mod NUM_REQ, and return to IDLE.
- Requester rules:
  - Dropping `req` mid-frame is ignored; the frame runs to completion.
  - Changing `req_len` mid-frame has no effect, because the length was latched at grant.
  - Requests from other requesters during a frame wait for IDLE.
- Backpressure: while `tx_ready` is low, `tx_data`, `tx_valid`, `grant` and `cnt` stay stable and no `data_pop` is issued.
- Arithmetic:
  - `cnt` is 8 bits and never wraps, since the zero-length case bypasses DATA.
  - `rr_ptr` is $clog2(NUM_REQ) bits and wraps modulo NUM_REQ.

## Timing
- Reset values, immediate on `reset` assertion: state IDLE, `grant` = 0, `data_pop` = 0, `frame_done` = 0, `busy` = 0, `tx_valid` = 0, `tx_data` = 0, `rr_ptr` = 0, `cnt` = 0, `csum_q` = 0.
- Reset mid-frame aborts the frame with no `frame_done`. The transmitter sees `tx_valid` fall asynchronously.
- Grant latency: `req` sampled high in IDLE at cycle N gives `grant` plus `tx_valid` with SYNC0 at cycle N+1.
- Throughput: with `tx_ready` held high, one byte per cycle. A frame occupies 3 + len (+1 with checksum) transfer cycles, plus 1 DONE cycle and at least 1 IDLE cycle before the next grant.
- `grant`, `frame_done`, `busy`, the state and `tx_valid` are registered. `data_pop` is combinational from state, `tx_ready` and `grant`.

## Configuration
- `FRAME_CHECKSUM_EN` defined:
  - CSUM state present.
  - `csum_q` is the XOR of the length byte and all payload bytes. It is reset to 0 in IDLE and updated on each LEN and DATA transfer.
  - The checksum is sent as the final byte.
- `FRAME_CHECKSUM_EN` undefined:
  - CSUM state and `csum_q` are absent.
  - LEN (when len = 0) and the last DATA transfer go directly to DONE.

## Structure
- Package `uart_frame_pkg` holds:
  - the state enum `frame_state_t`;
  - the default sync constants `FRAME_SYNC0` = 8'h55 and `FRAME_SYNC1` = 8'hAA;
  - the `FRAME_HDR_BYTES` = 3 constant.
- Sub-module `rr_arbiter`, parameterised by `NUM_REQ`:
  - inputs `req` and `rr_ptr`;
  - outputs a one-hot winner and its index. Purely combinational.
- The FSM, counters and output muxing live in `uart_frame_scheduler`.

## Test plan
- Single frame, checksum on: `req[1]` high, len 2, payload 0x11 then 0x22, `tx_ready` = 1.
  - TX stream 55 AA 02 11 22 31.
  - Two `data_pop[1]` pulses.
  - `frame_done` one cycle after the last byte.
- Simultaneous `req[0]` and `req[2]`, both held continuously: grant order 0, 2, 0, 2, with at least 1 idle cycle between frames.
- Zero length on `req[3]`:
  - stream 55 AA 00 00 with the checksum;
  - stream 55 AA 00 without it;
  - no `data_pop` in either case.
- Backpressure: `tx_ready` low for 5 cycles while in DATA.
  - `tx_data` and `tx_valid` stay stable.
  - No `data_pop`.
  - The frame resumes intact.
- Requester drops `req` after SYNC1: the full frame is still sent and `frame_done` pulses.
- Reset asserted mid-DATA: all outputs are 0 immediately. After release, a new request restarts from SYNC0 with `rr_ptr` = 0.
